// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS external memory arbiter.
// Holds the transaction FSM states, transfer size and bus drive-enable patterns.
package mips_pkg;

    localparam int BEATS = 4;

    localparam logic [7:0] OE_DRIVE = 8'hFF;
    localparam logic [7:0] OE_FLOAT = 8'h00;

    typedef enum logic [2:0] {
        IDLE,
        ADDR_HI,
        ADDR_LO,
        TURN,
        DATA,
        DONE
    } state_t;

    // Data beats go out most-significant byte first.
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/mips_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the one not served last.
// Purely combinational; last = 1 means requester 1 (data memory) was served last.
module mips_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] winner
);

    always_comb begin
        winner = req;
        if (&req) begin
            winner = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Arbitrates instruction-fetch and data-memory requesters onto a byte-wide external bus.
// Read grant 8 cycles after accept, write 7 (bus_rdy high); beats stall on bus_rdy low, ena low freezes all.
module mips_mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int BEATS  = mips_pkg::BEATS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic [31:0]       if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic              dm_gnt,
    output logic [31:0]       dm_rdata,
    output logic [7:0]        bus_out,
    output logic [7:0]        bus_oe,
    input  logic [7:0]        bus_in,
    output logic              bus_strb,
    output logic              bus_we,
    input  logic              bus_rdy
);
    import mips_pkg::*;

    localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              win_dm_q, win_dm_d;
    logic              last_dm_q, last_dm_d;
    logic [1:0]        beat_q, beat_d;
    logic [23:0]       shift_q, shift_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [31:0]       dm_rdata_q, dm_rdata_d;
    logic              if_gnt_q, if_gnt_d;
    logic              dm_gnt_q, dm_gnt_d;
    logic [7:0]        bus_out_q, bus_out_d;
    logic [7:0]        bus_oe_q, bus_oe_d;
    logic              bus_strb_q, bus_strb_d;
    logic              bus_we_q, bus_we_d;
    logic [1:0]        winner;

    mips_rr_arb2 u_arb (
        .req    ({dm_req, if_req}),
        .last   (last_dm_q),
        .winner (winner)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        win_dm_d   = win_dm_q;
        last_dm_d  = last_dm_q;
        beat_d     = beat_q;
        shift_d    = shift_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        if_gnt_d   = if_gnt_q;
        dm_gnt_d   = dm_gnt_q;
        bus_out_d  = bus_out_q;
        bus_oe_d   = bus_oe_q;
        bus_strb_d = bus_strb_q;
        bus_we_d   = bus_we_q;

        if (ena) begin
            case (state_q)
                IDLE: begin
                    if (if_req || dm_req) begin
                        win_dm_d = winner[1];
                        addr_d   = winner[0] ? if_addr : dm_addr;
                        we_d     = winner[1] & dm_we;
                        wdata_d  = dm_wdata;
                        beat_d   = 2'd0;
                        state_d  = ADDR_HI;
                    end
                end
                ADDR_HI: if (bus_rdy) state_d = ADDR_LO;
                ADDR_LO: if (bus_rdy) state_d = we_q ? DATA : TURN;
                TURN:    state_d = DATA;
                DATA: begin
                    if (bus_rdy) begin
                        beat_d = beat_q + 2'd1;
                        if (!we_q) shift_d = {shift_q[15:0], bus_in};
                        if (beat_q == LAST_BEAT) begin
                            state_d = DONE;
                            if (!we_q && win_dm_q)  dm_rdata_d = {shift_q, bus_in};
                            if (!we_q && !win_dm_q) if_rdata_d = {shift_q, bus_in};
                        end
                    end
                end
                DONE: begin
                    last_dm_d = win_dm_q;
                    state_d   = IDLE;
                end
                default: state_d = IDLE;
            endcase

            // Outputs are registered from the state being entered.
            bus_out_d  = OE_FLOAT;
            bus_oe_d   = OE_FLOAT;
            bus_strb_d = 1'b0;
            case (state_d)
                ADDR_HI: begin
                    bus_out_d  = addr_d[15:8];
                    bus_oe_d   = OE_DRIVE;
                    bus_strb_d = 1'b1;
                end
                ADDR_LO: begin
                    bus_out_d = addr_d[7:0];
                    bus_oe_d  = OE_DRIVE;
                end
                DATA: begin
                    if (we_d) begin
                        bus_out_d = word_byte(wdata_d, beat_d);
                        bus_oe_d  = OE_DRIVE;
                    end
                end
                default: ;
            endcase
            bus_we_d = (state_d != IDLE) && we_d;
            if_gnt_d = (state_d == DONE) && !win_dm_d;
            dm_gnt_d = (state_d == DONE) && win_dm_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            win_dm_q   <= 1'b0;
            last_dm_q  <= 1'b1;
            beat_q     <= 2'd0;
            shift_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            if_gnt_q   <= 1'b0;
            dm_gnt_q   <= 1'b0;
            bus_out_q  <= OE_FLOAT;
            bus_oe_q   <= OE_FLOAT;
            bus_strb_q <= 1'b0;
            bus_we_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            win_dm_q   <= win_dm_d;
            last_dm_q  <= last_dm_d;
            beat_q     <= beat_d;
            shift_q    <= shift_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            if_gnt_q   <= if_gnt_d;
            dm_gnt_q   <= dm_gnt_d;
            bus_out_q  <= bus_out_d;
            bus_oe_q   <= bus_oe_d;
            bus_strb_q <= bus_strb_d;
            bus_we_q   <= bus_we_d;
        end
    end

    // A frozen DONE must not stretch the grant pulse.
    assign if_gnt   = if_gnt_q & ena;
    assign dm_gnt   = dm_gnt_q & ena;
    assign if_rdata = if_rdata_q;
    assign dm_rdata = dm_rdata_q;
    assign bus_out  = bus_out_q;
    assign bus_oe   = bus_oe_q;
    assign bus_strb = bus_strb_q;
    assign bus_we   = bus_we_q;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter with a byte-bus slave model and write-byte capture.
module tb_mips_mem_arbiter;

    logic        clk, rst_n, ena;
    logic        if_req, if_gnt, dm_req, dm_we, dm_gnt;
    logic [15:0] if_addr, dm_addr;
    logic [31:0] if_rdata, dm_rdata, dm_wdata;
    logic [7:0]  bus_out, bus_oe, bus_in;
    logic        bus_strb, bus_we, bus_rdy;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int t0, t1;

    logic [31:0] rd_word;
    logic [2:0]  ph;
    logic [47:0] wbytes;
    int          wcnt;

    mips_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rdata(dm_rdata),
        .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in),
        .bus_strb(bus_strb), .bus_we(bus_we), .bus_rdy(bus_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave phase: 0 idle/addr-hi, 1 addr-lo, 2 turnaround, 3..6 data beats 0..3.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph <= 3'd0;
        end else if (ena) begin
            case (ph)
                3'd0: if (bus_strb && bus_rdy) ph <= 3'd1;
                3'd1: if (bus_rdy) ph <= bus_we ? 3'd3 : 3'd2;
                3'd2: ph <= 3'd3;
                3'd6: if (bus_rdy) ph <= 3'd0;
                default: if (bus_rdy) ph <= ph + 3'd1;
            endcase
        end
    end

    always_comb begin
        bus_in = 8'h00;
        case (ph)
            3'd3: bus_in = rd_word[31:24];
            3'd4: bus_in = rd_word[23:16];
            3'd5: bus_in = rd_word[15:8];
            3'd6: bus_in = rd_word[7:0];
            default: bus_in = 8'h00;
        endcase
    end

    // Log every driven byte accepted on the bus; a strobe starts a new log.
    always @(posedge clk) begin
        if (rst_n && ena && bus_rdy && bus_oe == 8'hFF) begin
            if (bus_strb) begin
                wbytes <= {40'd0, bus_out};
                wcnt   <= 1;
            end else begin
                wbytes <= {wbytes[39:0], bus_out};
                wcnt   <= wcnt + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_gnt(input int limit);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!(if_gnt || dm_gnt) && n < limit);
        chk("gnt_seen", 64'(if_gnt | dm_gnt), 64'd1);
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        if_req = 1'b0;
        dm_req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; bus_rdy = 1'b1;
        if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0; rd_word = '0;
        #12;
        chk("rst_if_gnt", 64'(if_gnt), 64'd0);
        chk("rst_dm_gnt", 64'(dm_gnt), 64'd0);
        chk("rst_rdata", {if_rdata, dm_rdata}, 64'd0);
        chk("rst_bus", {bus_out, bus_oe, 6'd0, bus_strb, bus_we}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single IF read of 0x1234
        if_addr = 16'h1234; rd_word = 32'hDEADBEEF; if_req = 1'b1;
        t0 = cyc;
        tick();
        chk("hi_out", 64'(bus_out), 64'h12);
        chk("hi_oe", 64'(bus_oe), 64'hFF);
        chk("hi_strb_we", {62'd0, bus_strb, bus_we}, 64'b10);
        tick();
        chk("lo_out", 64'(bus_out), 64'h34);
        chk("lo_strb", 64'(bus_strb), 64'd0);
        tick();
        chk("turn_oe", 64'(bus_oe), 64'h00);
        wait_gnt(20);
        chk("rd_lat", 64'(cyc - t0), 64'd8);
        chk("rd_gnt", {62'd0, if_gnt, dm_gnt}, 64'b10);
        chk("rd_data", 64'(if_rdata), 64'hDEADBEEF);
        if_req = 1'b0;
        tick();
        chk("rd_pulse", 64'(if_gnt), 64'd0);
        chk("rd_hold", 64'(if_rdata), 64'hDEADBEEF);

        // DM write 0xCAFEF00D to 0x00F0
        dm_addr = 16'h00F0; dm_wdata = 32'hCAFEF00D; dm_we = 1'b1; dm_req = 1'b1;
        t0 = cyc;
        wait_gnt(20);
        chk("wr_lat", 64'(cyc - t0), 64'd7);
        chk("wr_gnt", {62'd0, if_gnt, dm_gnt}, 64'b01);
        chk("wr_bytes", 64'(wbytes), 64'h00F0CAFEF00D);
        chk("wr_cnt", 64'(wcnt), 64'd6);
        chk("wr_we", 64'(bus_we), 64'd1);
        chk("wr_no_rdata", 64'(dm_rdata), 64'd0);
        dm_req = 1'b0;
        tick();
        chk("idle_oe", {bus_oe, bus_out, 7'd0, bus_we}, 64'd0);

        // Simultaneous requests after reset alternate IF, DM, IF
        do_reset();
        if_addr = 16'h1000; dm_addr = 16'h2000; dm_we = 1'b0; rd_word = 32'h11223344;
        if_req = 1'b1; dm_req = 1'b1;
        wait_gnt(20);
        chk("alt1", {62'd0, if_gnt, dm_gnt}, 64'b10);
        t1 = cyc;
        wait_gnt(20);
        chk("alt2", {62'd0, if_gnt, dm_gnt}, 64'b01);
        chk("alt2_gap", 64'(cyc - t1), 64'd9);
        chk("alt2_data", 64'(dm_rdata), 64'h11223344);
        wait_gnt(20);
        chk("alt3", {62'd0, if_gnt, dm_gnt}, 64'b10);
        if_req = 1'b0; dm_req = 1'b0;
        tick();

        // Write with bus_rdy low for 3 cycles during data beat 1
        dm_addr = 16'h1357; dm_wdata = 32'h89ABCDEF; dm_we = 1'b1; dm_req = 1'b1;
        t0 = cyc;
        repeat (4) tick();
        chk("st_b1", 64'(bus_out), 64'hAB);
        bus_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("st_hold", {bus_oe, bus_out}, 64'hFFAB);
            chk("st_gnt", 64'(dm_gnt), 64'd0);
        end
        bus_rdy = 1'b1;
        wait_gnt(20);
        chk("st_lat", 64'(cyc - t0), 64'd10);
        chk("st_bytes", 64'(wbytes), 64'h135789ABCDEF);
        dm_req = 1'b0;
        tick();

        // Reset pulse during data beat 2 of a write
        dm_addr = 16'h0A0A; dm_wdata = 32'h01020304; dm_we = 1'b1; dm_req = 1'b1;
        repeat (5) tick();
        chk("rs_pre_oe", 64'(bus_oe), 64'hFF);
        rst_n = 1'b0; dm_req = 1'b0;
        #1;
        chk("rs_bus", {bus_oe, bus_out, 6'd0, bus_strb, bus_we}, 64'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rs_no_gnt", {62'd0, if_gnt, dm_gnt}, 64'd0);
        end
        if_addr = 16'h0BAD; rd_word = 32'h600DF00D; if_req = 1'b1;
        t0 = cyc;
        wait_gnt(20);
        chk("rs_next_lat", 64'(cyc - t0), 64'd8);
        chk("rs_next_data", 64'(if_rdata), 64'h600DF00D);
        if_req = 1'b0;
        tick();

        // ena low for 2 cycles in ADDR_LO of a DM read
        dm_addr = 16'h4321; dm_we = 1'b0; rd_word = 32'h13579BDF; dm_req = 1'b1;
        t0 = cyc;
        repeat (2) tick();
        chk("en_pre", 64'(bus_out), 64'h21);
        ena = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("en_frozen", {bus_oe, bus_out, 7'd0, bus_strb}, {8'hFF, 8'h21, 8'h00});
        end
        ena = 1'b1;
        wait_gnt(20);
        chk("en_lat", 64'(cyc - t0), 64'd10);
        chk("en_data", 64'(dm_rdata), 64'h13579BDF);
        chk("en_if_hold", 64'(if_rdata), 64'h600DF00D);

        // ena dropped while in DONE masks the grant and holds DONE
        ena = 1'b0;
        #1;
        chk("dn_mask", 64'(dm_gnt), 64'd0);
        dm_req = 1'b0;
        tick();
        chk("dn_frozen", 64'(dm_gnt), 64'd0);
        ena = 1'b1;
        #1;
        chk("dn_resume", 64'(dm_gnt), 64'd1);
        tick();
        chk("dn_end", 64'(dm_gnt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/mips_mem_arbiter.md
MIPS_MEM_ARBITER -- requirements
Module: mips_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, width of requester word addresses; fixed at 16 for this release.
REQ-002 SHALL have parameter BEATS, default 4, bytes per 32-bit word transfer.
REQ-003 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port ena  in  1  global enable; low freezes all state.
REQ-006 SHALL have ports if_req in 1, if_addr in 16, if_gnt out 1, if_rdata out 32: instruction-fetch requester, read only.
REQ-007 SHALL have ports dm_req in 1, dm_we in 1, dm_addr in 16, dm_wdata in 32, dm_gnt out 1, dm_rdata out 32: data-memory requester.
REQ-008 SHALL have ports bus_out out 8, bus_oe out 8, bus_in in 8: shared byte-wide external memory bus (maps to uio pins).
REQ-009 SHALL have ports bus_strb out 1 (command start), bus_we out 1 (write cycle), bus_rdy in 1 (external beat ready).

Function
REQ-010 SHALL implement states IDLE, ADDR_HI, ADDR_LO, TURN, DATA, DONE.
REQ-011 IDLE: on any request, SHALL pick a winner, latch its addr/we/wdata and go to ADDR_HI next cycle.
REQ-012 Arbitration SHALL be 2-way round-robin: both requesting -> grant the one not served last; single request -> grant it; last-winner resets to DM (IF wins first tie).
REQ-013 IF requests SHALL always be reads; bus_we = latched dm_we for DM, 0 for IF, held for whole transaction.
REQ-014 ADDR_HI: bus_out = addr[15:8], bus_oe = 8'hFF, bus_strb = 1; ADDR_LO: bus_out = addr[7:0], bus_oe = 8'hFF, bus_strb = 0.
REQ-015 ADDR_HI/ADDR_LO/DATA beats SHALL advance only on a cycle with bus_rdy = 1; otherwise hold outputs.
REQ-016 After ADDR_LO: read -> TURN (one cycle, bus_oe = 0, no bus_rdy wait) -> DATA; write -> DATA directly.
REQ-017 DATA SHALL transfer BEATS bytes MSB first via 2-bit beat counter wrapping 3->0; write drives wdata byte, bus_oe = FF; read sets bus_oe = 0 and samples bus_in into rdata shift register when bus_rdy = 1.
REQ-018 After beat 3 accepted SHALL enter DONE: pulse winner's gnt for exactly one cycle with rdata valid (reads), update last-winner, return to IDLE.
REQ-019 if_rdata/dm_rdata SHALL hold last completed read value until next completion for that requester.
REQ-020 Latency with bus_rdy tied 1: read gnt 8 cycles after IDLE accept, write 7 cycles; back-to-back transactions SHALL insert exactly one IDLE cycle.
REQ-021 Requester SHALL keep req high until gnt; request drop mid-transaction SHALL NOT abort it; req still high in cycle after gnt counts as new request.
REQ-022 ena = 0 SHALL freeze FSM, counters, latches and all outputs (gnt pulse extends while frozen is forbidden: gnt forced 0 when ena = 0, DONE held).
REQ-023 Outside ADDR_HI/ADDR_LO/write-DATA, bus_oe SHALL be 8'h00 and bus_out 8'h00.

Reset
REQ-024 rst_n low SHALL asynchronously force IDLE, beat count 0, last-winner DM, gnts 0, rdata 0, bus_out 0, bus_oe 0, bus_strb 0, bus_we 0.
REQ-025 Reset mid-transaction SHALL abandon it with no gnt; after release first cycle is IDLE.

Structure
REQ-026 Shared package mips_pkg SHALL hold state enum, BEATS, bus OE constants (OE_DRIVE = FF, OE_FLOAT = 00).
REQ-027 Round-robin pick SHALL be sub-module mips_rr_arb2 (inputs req[1:0], last; output winner one-hot); remainder flat.

Verification
REQ-028 Single IF read addr 0x1234, bus_rdy = 1, bus_in beats 0xDE,0xAD,0xBE,0xEF -> bus_out 0x12,0x34, if_gnt at cycle 8, if_rdata = 0xDEADBEEF.
REQ-029 DM write addr 0x00F0 data 0xCAFEF00D -> bus_we = 1, bus_out 0x00,0xF0,0xCA,0xFE,0xF0,0x0D with bus_oe = FF, dm_gnt at cycle 7.
REQ-030 IF and DM asserted same cycle after reset, both held -> IF served first, DM second, IF third (alternation).
REQ-031 bus_rdy low 3 cycles during DATA beat 1 -> outputs hold, gnt delayed exactly 3 cycles, data intact.
REQ-032 rst_n pulsed low during DATA beat 2 -> immediate bus_oe = 0, no gnt, next request completes normally.
REQ-033 ena low 2 cycles mid-ADDR_LO -> state and bus outputs frozen, gnt delayed 2 cycles.
